// File: rtl/tse_pcs_cfg_seq_if.sv
// ---------------------------------------------------------------------------
// tse_pcs_cfg_seq_if
// Shared control-port bus between the configuration sequencer and N_CH
// triple-speed Ethernet PCS instances.
//   reg_addr     : shared 5-bit register address       (master -> slave)
//   reg_data_in  : shared 16-bit write data            (master -> slave)
//   reg_wr       : per-channel write strobe            (master -> slave)
//   reg_rd       : per-channel read strobe             (master -> slave)
//   reg_data_out : per-channel read data, channel c at [16c+15:16c] (slave -> master)
//   reg_busy     : per-channel waitrequest             (slave -> master)
// ---------------------------------------------------------------------------
interface tse_pcs_cfg_seq_if #(
  parameter int N_CH = 4
);
  logic [4:0]         reg_addr;
  logic [15:0]        reg_data_in;
  logic [N_CH-1:0]    reg_wr;
  logic [N_CH-1:0]    reg_rd;
  logic [16*N_CH-1:0] reg_data_out;
  logic [N_CH-1:0]    reg_busy;

  modport master (
    output reg_addr, reg_data_in, reg_wr, reg_rd,
    input  reg_data_out, reg_busy
  );

  modport slave (
    input  reg_addr, reg_data_in, reg_wr, reg_rd,
    output reg_data_out, reg_busy
  );
endinterface

// File: rtl/tse_pcs_cfg_seq.sv
// ---------------------------------------------------------------------------
// tse_pcs_cfg_seq
// Configures up to N_CH TSE PCS/SGMII channels (IF_MODE then CONTROL) and
// then polls status / link-partner ability round-robin, publishing per-channel
// link, speed and duplex.
// Ports:
//   clk        : control-port clock
//   reset      : asynchronous active-high reset
//   cfg_start  : one-cycle pulse, (re)configure all channels
//   pcs        : control-port bus (master side), see tse_pcs_cfg_seq_if
//   cfg_done   : all channels configured; cleared by a restart
//   link_up    : per channel, AN complete and link status set
//   speed      : per channel 2 bits, 10=1000, 01=100, 00=10
//   full_dup   : per channel link-partner duplex bit
//   err        : per channel sticky control-port timeout flag
// ---------------------------------------------------------------------------
module tse_pcs_cfg_seq #(
  parameter int          N_CH        = 4,
  parameter logic [15:0] IF_MODE_VAL = 16'h0003,
  parameter logic [15:0] CTRL_VAL    = 16'h1200,
  parameter int          POLL_DIV    = 1000,
  parameter int          TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  tse_pcs_cfg_seq_if.master pcs,
  output logic              cfg_done,
  output logic [N_CH-1:0]   link_up,
  output logic [2*N_CH-1:0] speed,
  output logic [N_CH-1:0]   full_dup,
  output logic [N_CH-1:0]   err
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int PC_W  = $clog2(POLL_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_IFMODE, S_WR_CTRL, S_NEXT_CFG,
    S_POLL_WAIT, S_RD_STAT, S_RD_PART, S_NEXT_POLL
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              stb_q, stb_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic [N_CH-1:0]   link_q, link_d;
  logic [2*N_CH-1:0] speed_q, speed_d;
  logic [N_CH-1:0]   dup_q, dup_d;
  logic [N_CH-1:0]   err_q, err_d;

  // Per-channel read words split out of the flat bus
  logic [15:0] rd_word [N_CH];
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_rd_word
    assign rd_word[gi] = pcs.reg_data_out[16*gi +: 16];
  end

  logic        xfer_state, busy_c, xfer_ok, xfer_to, xfer_end;
  logic [15:0] sel_word;
  logic [1:0]  part_spd;
  logic        unused_bits;

  assign xfer_state = (state_q == S_WR_IFMODE) || (state_q == S_WR_CTRL) ||
                      (state_q == S_RD_STAT)   || (state_q == S_RD_PART);
  assign busy_c   = pcs.reg_busy[ch_q];
  assign xfer_ok  = stb_q && !busy_c;
  // Completion wins over timeout on the last allowed cycle
  assign xfer_to  = stb_q && busy_c && (tmr_q == TMR_W'(TIMEOUT - 1));
  assign xfer_end = xfer_ok || xfer_to;
  // A timed-out read is treated as all zeros
  assign sel_word = xfer_ok ? rd_word[ch_q] : 16'h0000;
  assign part_spd = (sel_word[11:10] == 2'b11) ? 2'b00 : sel_word[11:10];
  // Status / partner bits this sequencer does not interpret
  assign unused_bits = ^{sel_word[14:13], sel_word[9:6], sel_word[4:3], sel_word[1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      stb_q   <= 1'b0;
      tmr_q   <= '0;
      pc_q    <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      link_q  <= '0;
      speed_q <= '0;
      dup_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      stb_q   <= stb_d;
      tmr_q   <= tmr_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      link_q  <= link_d;
      speed_q <= speed_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    stb_d   = stb_q;
    tmr_d   = tmr_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    done_d  = done_q;
    link_d  = link_q;
    speed_d = speed_q;
    dup_d   = dup_q;
    err_d   = err_q;

    if (state_q != S_IDLE && cfg_start) pend_d = 1'b1;

    // Each transfer state spends one cycle with the strobe low (the idle gap)
    // before raising it, so consecutive transfers are always separated.
    if (xfer_state) begin
      if (!stb_q) begin
        stb_d = 1'b1;
        tmr_d = '0;
      end else if (xfer_end) begin
        stb_d = 1'b0;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end

    if (xfer_to) err_d[ch_q] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_WR_IFMODE;
          ch_d    = '0;
        end
      end
      S_WR_IFMODE: if (xfer_end) state_d = S_WR_CTRL;
      S_WR_CTRL:   if (xfer_end) state_d = S_NEXT_CFG;
      S_NEXT_CFG: begin
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = S_POLL_WAIT;
          ch_d    = '0;
          pc_d    = '0;
          done_d  = 1'b1;
        end else begin
          state_d = S_WR_IFMODE;
          ch_d    = ch_q + CH_W'(1);
        end
      end
      S_POLL_WAIT: begin
        if (pc_q == PC_W'(POLL_DIV - 1)) begin
          pc_d    = '0;
          state_d = S_RD_STAT;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_RD_STAT: begin
        if (xfer_end) begin
          // Partner ability is only meaningful once AN is complete with link
          if (sel_word[5] && sel_word[2]) begin
            state_d = S_RD_PART;
          end else begin
            link_d[ch_q]              = 1'b0;
            speed_d[{ch_q, 1'b0} +: 2] = 2'b00;
            dup_d[ch_q]               = 1'b0;
            state_d                   = S_NEXT_POLL;
          end
        end
      end
      S_RD_PART: begin
        if (xfer_end) begin
          link_d[ch_q]              = sel_word[15];
          speed_d[{ch_q, 1'b0} +: 2] = part_spd;
          dup_d[ch_q]               = sel_word[12];
          state_d                   = S_NEXT_POLL;
        end
      end
      S_NEXT_POLL: begin
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = S_POLL_WAIT;
          ch_d    = '0;
          pc_d    = '0;
        end else begin
          state_d = S_RD_STAT;
          ch_d    = ch_q + CH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A requested restart waits for any in-flight transfer to finish; outside
    // a transfer it takes effect immediately. err is deliberately kept.
    if (state_q != S_IDLE && (pend_q || cfg_start) && (!xfer_state || xfer_end)) begin
      state_d = S_WR_IFMODE;
      ch_d    = '0;
      stb_d   = 1'b0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      link_d  = '0;
      speed_d = '0;
      dup_d   = '0;
    end
  end

  // Output logic
  logic [4:0]      bus_addr;
  logic [15:0]     bus_wdata;
  logic [N_CH-1:0] bus_wr, bus_rd;

  always_comb begin
    bus_addr  = 5'h00;
    bus_wdata = 16'h0000;
    bus_wr    = '0;
    bus_rd    = '0;
    case (state_q)
      S_WR_IFMODE: begin bus_addr = 5'h14; bus_wdata = IF_MODE_VAL; end
      S_WR_CTRL:   begin bus_addr = 5'h00; bus_wdata = CTRL_VAL;    end
      S_RD_STAT:   bus_addr = 5'h01;
      S_RD_PART:   bus_addr = 5'h05;
      default:     bus_addr = 5'h00;
    endcase
    if (stb_q) begin
      if (state_q == S_WR_IFMODE || state_q == S_WR_CTRL) bus_wr[ch_q] = 1'b1;
      else if (state_q == S_RD_STAT || state_q == S_RD_PART) bus_rd[ch_q] = 1'b1;
    end
  end

  assign pcs.reg_addr    = bus_addr;
  assign pcs.reg_data_in = bus_wdata;
  assign pcs.reg_wr      = bus_wr;
  assign pcs.reg_rd      = bus_rd;
  assign cfg_done        = done_q;
  assign link_up         = link_q;
  assign speed           = speed_q;
  assign full_dup        = dup_q;
  assign err             = err_q;
endmodule

// File: doc/tse_pcs_cfg_seq.md
Name: tse_pcs_cfg_seq

Overview:
Parametrised configuration and link-monitor sequencer for up to N_CH triple-speed Ethernet PCS/SGMII channels. It drives each channel's 5-bit/16-bit control port (waitrequest handshake) to program SGMII mode and start auto-negotiation. It then polls status round-robin and publishes per-channel link, speed and duplex to the MAC/clock-enable logic. It sits between the system reset/control logic and the PCS instances.

Parameters:
N_CH, 4, number of PCS channels (1..16); CH_W = max(1, clog2(N_CH))
IF_MODE_VAL, 16'h0003, value written to IF_MODE (addr 5'h14): SGMII_ENA, USE_SGMII_AN
CTRL_VAL, 16'h1200, value written to CONTROL (addr 5'h00): AN enable, AN restart
POLL_DIV, 1000, clk cycles between polling rounds (>=1)
TIMEOUT, 255, max clk cycles a strobe is held with reg_busy high (>=1)

Ports:
clk  in  1  control-port clock; all logic synchronous to it
reset  in  1  asynchronous active-high reset
cfg_start  in  1  one-cycle pulse: (re)configure all channels
reg_addr  out  5  shared register address
reg_data_in  out  16  shared write data
reg_wr  out  N_CH  per-channel write strobe
reg_rd  out  N_CH  per-channel read strobe
reg_data_out  in  16*N_CH  per-channel read data, channel c at [16c+15:16c]
reg_busy  in  N_CH  per-channel waitrequest
cfg_done  out  1  high once all channels configured; cleared by cfg_start
link_up  out  N_CH  AN complete and link status set
speed  out  2*N_CH  per channel: 2'b10=1000, 2'b01=100, 2'b00=10
full_dup  out  N_CH  partner duplex bit
err  out  N_CH  sticky: control-port timeout seen on channel

Behaviour:
- Reset: all strobes 0, reg_addr 0, reg_data_in 0, cfg_done 0, link_up/speed/full_dup/err 0, FSM IDLE, channel index 0, poll counter 0.
- Transfer rule: one strobe (of one channel) asserted at a time, with reg_addr/reg_data_in stable. Strobe held until the first rising edge with reg_busy[c]=0. That edge completes the transfer; read data is sampled on it. Strobe deasserts the next cycle. Minimum 1 idle cycle between transfers.
- Timeout: counter starts at strobe assertion. If reg_busy[c] is still high after TIMEOUT cycles, the strobe drops, err[c] is set, and the FSM advances as if complete; read data is treated as 0. If busy falls on the timeout cycle, completion wins and no err is raised.
- FSM states: IDLE -> WR_IFMODE -> WR_CTRL -> NEXT_CFG. NEXT_CFG goes to WR_IFMODE for channel+1, or to POLL_WAIT for the last channel, and sets cfg_done=1. POLL_WAIT -> RD_STAT -> (RD_PART | NEXT_POLL) -> NEXT_POLL -> RD_STAT (channel+1) or POLL_WAIT (after last channel).
- IDLE exits only on cfg_start; cfg_start is ignored until then.
- POLL_WAIT counts POLL_DIV cycles, then reads channels 0..N_CH-1 in order.
- RD_STAT reads addr 5'h01. If bit5 (AN complete) and bit2 (link) are both 1, go to RD_PART. Otherwise clear link_up[c], speed[c], full_dup[c] and go to NEXT_POLL.
- RD_PART reads addr 5'h05. Set link_up[c]=bit15, speed[c]=bits[11:10] (2'b11 maps to 2'b00), full_dup[c]=bit12. Outputs update on the completing edge.
- cfg_start while not IDLE sets a pending flag. When the in-flight transfer completes or times out, the FSM clears cfg_done and link_up/speed/full_dup (not err) and restarts at WR_IFMODE, channel 0. err clears only on reset.
- Reset mid-transfer: strobes drop immediately (asynchronous); no completion is recorded.

Test Plan:
- N_CH=2, busy low always; pulse cfg_start -> writes (ch0,14h,0003),(ch0,00h,1200),(ch1,14h,0003),(ch1,00h,1200) in order, each strobe 1 cycle; cfg_done=1 after 4th.
- ch1 busy held 3 cycles on first write -> reg_wr[1] high exactly 4 cycles, data/addr stable, err=0.
- Poll: ch0 status 0x0024, partner 0x9800 -> link_up[0]=1, speed[1:0]=2'b10, full_dup[0]=1. Next round status 0x0020 -> all three cleared, no partner read issued.
- ch0 busy stuck high -> strobe drops after 255 cycles, err[0]=1, ch1 still configured, cfg_done=1; busy falling on cycle 255 -> err stays 0.
- cfg_start mid-poll during busy-held read -> read completes, then cfg_done=0, link_up=0, WR_IFMODE ch0 begins next transfer.
- Assert reset while reg_rd active -> all outputs 0 same cycle; after release, no activity until cfg_start.
